conv_window_ctrl: RTL and testbench
===================================

// Module: conv_window_ctrl
// PURPOSE
//  Sequences a raster pixel stream into the KxK line-buffer array (chain of variable-depth
//  shift registers) ahead of the convolution MAC array. Tracks row/col position, drives the
//  line-buffer shift enable and flags each cycle a complete, stride-aligned KxK window is
//  present. Applies valid/ready backpressure from the MAC array back to the pixel source.
// PARAMETERS
//  WIDTH   16  pixel width in bits
//  IMG_W   28  image width in pixels (>= K)
//  IMG_H   28  image height in pixels (>= K)
//  K       3   kernel size (>= 1)
//  STRIDE  1   window stride, rows and cols (>= 1)
// PORTS
//  clk          in   1                    rising-edge clock
//  reset        in   1                    asynchronous, active-low reset
//  start        in   1                    begin a frame (sampled in IDLE only)
//  in_valid     in   1                    source pixel valid
//  in_ready     out  1                    controller accepts pixel this cycle
//  in_data      in   WIDTH                source pixel
//  lb_shift_en  out  1                    advance line buffers one position
//  lb_din       out  WIDTH                pixel into line buffers (= in_data)
//  win_valid    out  1                    full aligned window present in line buffers
//  win_ready    in   1                    MAC array consumes window
//  out_row      out  $clog2(IMG_H)        output-map row of presented window
//  out_col      out  $clog2(IMG_W)        output-map col of presented window
//  busy         out  1                    high from start accept until frame_done
//  frame_done   out  1                    one-cycle pulse, frame complete
// BEHAVIOUR
//  - Reset (reset=0): state IDLE; counters 0; in_ready, lb_shift_en, win_valid, busy,
//    frame_done, out_row, out_col all 0. Takes effect immediately, including mid-frame.
//  - FSM: IDLE -start-> RUN (busy=1, row=col=0). RUN -last pixel accepted-> DRAIN.
//    DRAIN -no pending window (win_valid=0, or win_valid&win_ready)-> DONE.
//    DONE -> IDLE next cycle, frame_done=1 for that DONE cycle, busy=0 in IDLE.
//  - start outside IDLE is ignored; start and in_valid in same IDLE cycle: pixel not accepted.
//  - in_ready = (state==RUN) && !(win_valid && !win_ready) (combinational).
//  - accept = in_valid && in_ready. lb_shift_en = accept, lb_din = in_data (same cycle,
//    combinational; line buffers capture on that edge).
//  - On accept: col++ ; col==IMG_W-1 wraps to 0 and row++. Last pixel = (IMG_H-1, IMG_W-1).
//  - Window test on accepted pixel (r,c): r>=K-1, c>=K-1, (r-K+1)%STRIDE==0,
//    (c-K+1)%STRIDE==0; implemented with per-axis stride phase counters, no dividers.
//  - win_valid registered: rises the cycle after a qualifying accept; out_row/out_col load
//    (r-K+1)/STRIDE, (c-K+1)/STRIDE from output counters on the same edge. Held stable
//    until win_valid && win_ready; cleared next cycle unless a new qualifying accept
//    coincides (back-to-back windows, 1 per cycle at full rate).
//  - Stalled window (win_valid=1, win_ready=0): in_ready=0, no shift, buffers frozen.
//  - Output counters wrap row-major; out_col resets to 0 on each new output row.
// CONFIGURATION
//  CONV_WIN_PERF_EN defined: adds output stall_cycles [31:0]; counts cycles with
//   win_valid && !win_ready; cleared by reset and on accepted start; saturates at 2^32-1.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING (WIDTH=16 unless noted)
//  1 IMG 4x4,K=3,S=1, in_valid=1, win_ready=1, pixels 0..15 -> win_valid cycles after
//    pixels 10,11,14,15 with (out_row,out_col)=(0,0),(0,1),(1,0),(1,1); frame_done 1 pulse.
//  2 IMG 5x5,K=3,S=2 -> exactly 4 windows, after pixels 12,14,22,24, coords (0,0)..(1,1).
//  3 Test 1 with win_ready=0 for 5 cycles at first window -> in_ready=0, lb_shift_en=0,
//    win_valid/out_row/out_col stable 5 cycles; resumes, same 4 windows, no pixel lost.
//  4 reset=0 after pixel 7 of test 1 -> all outputs 0 immediately, IDLE; new start runs
//    a clean frame matching test 1.
//  5 start pulsed during RUN and in_valid with start in IDLE -> ignored/not accepted;
//    window count and coords unchanged vs test 1.
//  6 CONV_WIN_PERF_EN, test 3 stimulus -> stall_cycles=5 at frame_done; next start -> 0.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: walks a raster pixel stream into the KxK line-buffer chain,
// tracks row/col position, flags each stride-aligned complete window and
// applies MAC-side backpressure to the pixel source.
// Optional build macro: CONV_WIN_PERF_EN adds the stall_cycles counter output.
module conv_window_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             lb_shift_en,
  output logic [WIDTH-1:0] lb_din,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             frame_done
`ifdef CONV_WIN_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int unsigned PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PH_W-1:0]  row_ph_q, row_ph_d;
  logic [PH_W-1:0]  col_ph_q, col_ph_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic             win_valid_q, win_valid_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
`ifdef CONV_WIN_PERF_EN
  logic [31:0]      stall_q, stall_d;
`endif

  logic win_stall;
  logic accept;
  logic last_col;
  logic last_row;
  logic row_hit;
  logic col_hit;
  logic win_hit;

  // Handshake, position qualifiers and next-state for every register
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    row_ph_d     = row_ph_q;
    col_ph_d     = col_ph_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    win_valid_d  = win_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
`ifdef CONV_WIN_PERF_EN
    stall_d      = stall_q;
`endif

    win_stall   = win_valid_q && !win_ready;
    in_ready    = (state_q == S_RUN) && !win_stall;
    accept      = in_valid && in_ready;
    lb_shift_en = accept;
    lb_din      = in_data;

    last_col = (col_q == COL_W'(IMG_W - 1));
    last_row = (row_q == ROW_W'(IMG_H - 1));
    // Phase counters stay at zero until the axis reaches K-1, then cycle mod STRIDE
    row_hit  = (row_q >= ROW_W'(K - 1)) && (row_ph_q == '0);
    col_hit  = (col_q >= COL_W'(K - 1)) && (col_ph_q == '0);
    win_hit  = accept && row_hit && col_hit;

    // Presented window is released on consume, replaced by a coinciding new one
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end
    if (win_hit) begin
      win_valid_d = 1'b1;
      out_row_d   = orow_q;
      out_col_d   = ocol_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          row_d    = '0;
          col_d    = '0;
          row_ph_d = '0;
          col_ph_d = '0;
          orow_d   = '0;
          ocol_d   = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (last_col) begin
            col_d    = '0;
            col_ph_d = '0;
            ocol_d   = '0;
            if (row_hit) begin
              orow_d = orow_q + ROW_W'(1);
            end
            if (last_row) begin
              row_d    = '0;
              row_ph_d = '0;
              orow_d   = '0;
              state_d  = S_DRAIN;
            end else begin
              row_d = row_q + ROW_W'(1);
              if (row_q >= ROW_W'(K - 1)) begin
                row_ph_d = (row_ph_q == PH_W'(STRIDE - 1)) ? '0 : row_ph_q + PH_W'(1);
              end
            end
          end else begin
            col_d = col_q + COL_W'(1);
            if (col_q >= COL_W'(K - 1)) begin
              col_ph_d = (col_ph_q == PH_W'(STRIDE - 1)) ? '0 : col_ph_q + PH_W'(1);
            end
            if (win_hit) begin
              ocol_d = ocol_q + COL_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (!win_valid_q || win_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);

`ifdef CONV_WIN_PERF_EN
    // Stall counter: cleared by an accepted start, saturating otherwise
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (win_stall && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
`endif
  end

  // State and datapath registers, asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      row_ph_q     <= '0;
      col_ph_q     <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      win_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef CONV_WIN_PERF_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      row_ph_q     <= row_ph_d;
      col_ph_q     <= col_ph_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      win_valid_q  <= win_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef CONV_WIN_PERF_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign win_valid  = win_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef CONV_WIN_PERF_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: instance 0 is 4x4/K3/S1, instance 1 is 5x5/K3/S2.
// A raster-level model predicts every output each cycle; window lists are pinned
// against hand-computed literals.
`timescale 1ns/1ps
module tb_conv_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_s[2];
  logic        in_valid_s[2];
  logic        win_ready_s[2];
  logic [15:0] in_data_s[2];
  wire         in_ready_s[2];
  wire         lb_shift_en_s[2];
  wire  [15:0] lb_din_s[2];
  wire         win_valid_s[2];
  wire         busy_s[2];
  wire         frame_done_s[2];
`ifdef CONV_WIN_PERF_EN
  wire  [31:0] stall_s[2];
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int win_log[2][$];
  int trig_log[2][$];
  int din_log[2][$];
  int mstall[2];

  task automatic check(input int inst, input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL u%0d %s: got %0d expected %0d", inst, name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int IW   = (g == 0) ? 4 : 5;
    localparam int IH   = IW;
    localparam int KK   = 3;
    localparam int SS   = (g == 0) ? 1 : 2;
    localparam int NPIX = IW * IH;
    localparam int RW   = $clog2(IH);
    localparam int CW   = $clog2(IW);

    wire [RW-1:0] orow;
    wire [CW-1:0] ocol;

    conv_window_ctrl #(
      .WIDTH(16), .IMG_W(IW), .IMG_H(IH), .K(KK), .STRIDE(SS)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s[g]),
      .in_valid   (in_valid_s[g]),
      .in_ready   (in_ready_s[g]),
      .in_data    (in_data_s[g]),
      .lb_shift_en(lb_shift_en_s[g]),
      .lb_din     (lb_din_s[g]),
      .win_valid  (win_valid_s[g]),
      .win_ready  (win_ready_s[g]),
      .out_row    (orow),
      .out_col    (ocol),
      .busy       (busy_s[g]),
      .frame_done (frame_done_s[g])
`ifdef CONV_WIN_PERF_EN
      ,
      .stall_cycles(stall_s[g])
`endif
    );

    // Model: 0 idle, 1 streaming/draining, 3 done pulse
    int ph = 0, pix = 0, pr = 0, pc = 0, stl = 0;
    bit pend = 1'b0;

    always @(negedge clk) begin
      bit er, acc;
      int r, c;
      if (!reset) begin
        ph = 0; pix = 0; pend = 1'b0; stl = 0;
        check(g, "rst_in_ready", in_ready_s[g], 0);
        check(g, "rst_win_valid", win_valid_s[g], 0);
        check(g, "rst_busy", busy_s[g], 0);
        check(g, "rst_frame_done", frame_done_s[g], 0);
        check(g, "rst_lb_shift_en", lb_shift_en_s[g], 0);
        check(g, "rst_out_row", orow, 0);
        check(g, "rst_out_col", ocol, 0);
      end else begin
        er  = (ph == 1) && (pix < NPIX) && !(pend && !win_ready_s[g]);
        acc = er && in_valid_s[g];
        check(g, "in_ready", in_ready_s[g], er);
        check(g, "lb_shift_en", lb_shift_en_s[g], acc);
        check(g, "win_valid", win_valid_s[g], pend);
        check(g, "busy", busy_s[g], ph != 0);
        check(g, "frame_done", frame_done_s[g], ph == 3);
        if (acc) check(g, "lb_din", lb_din_s[g], in_data_s[g]);
        if (pend) begin
          check(g, "out_row", orow, pr);
          check(g, "out_col", ocol, pc);
        end
`ifdef CONV_WIN_PERF_EN
        check(g, "stall_cycles", stall_s[g], stl);
`endif
        if (win_valid_s[g] && win_ready_s[g]) win_log[g].push_back(int'(orow) * 16 + int'(ocol));
        if (lb_shift_en_s[g]) din_log[g].push_back(int'(lb_din_s[g]));
        if (ph == 3) mstall[g] = stl;
        if (pend && !win_ready_s[g]) stl++;
        case (ph)
          0: if (start_s[g]) begin ph = 1; pix = 0; pend = 1'b0; stl = 0; end
          1: begin
            if (pix == NPIX) begin
              if (!pend || win_ready_s[g]) ph = 3;
              if (win_ready_s[g]) pend = 1'b0;
            end else if (acc) begin
              r = pix / IW;
              c = pix % IW;
              if (r >= KK - 1 && c >= KK - 1 && (r - KK + 1) % SS == 0 && (c - KK + 1) % SS == 0) begin
                pend = 1'b1;
                pr = (r - KK + 1) / SS;
                pc = (c - KK + 1) / SS;
                trig_log[g].push_back(pix);
              end else if (win_ready_s[g]) begin
                pend = 1'b0;
              end
              pix++;
            end else if (win_ready_s[g]) begin
              pend = 1'b0;
            end
          end
          default: ph = 0;
        endcase
      end
    end
  end

  // Stream one frame; start is raised together with in_valid and pixel 0
  task automatic run_frame(input int g, input int npix, input bit stall, input int rst_after,
                           input bit glitch, output bit done);
    int  acc_n = 0;
    int  sc    = 0;
    int  cyc   = 0;
    bit  a, fd;
    done = 1'b0;
    win_log[g].delete(); trig_log[g].delete(); din_log[g].delete();
    mstall[g] = -1;
    @(posedge clk); #1;
    start_s[g] = 1'b1; in_valid_s[g] = 1'b1; in_data_s[g] = 16'd0; win_ready_s[g] = !stall;
    while (cyc < 400) begin
      @(negedge clk);
      a  = in_valid_s[g] && in_ready_s[g];
      fd = frame_done_s[g];
      @(posedge clk); #1;
      cyc++;
`ifdef CONV_WIN_PERF_EN
      if (cyc == 1) check(g, "stall_after_start", stall_s[g], 0);
`endif
      if (fd) begin
`ifdef CONV_WIN_PERF_EN
        check(g, "stall_at_done", stall_s[g], stall ? 5 : 0);
`endif
        done = 1'b1;
        break;
      end
      if (a) begin
        acc_n++;
        in_data_s[g] = 16'(acc_n);
        if (acc_n == npix) in_valid_s[g] = 1'b0;
      end
      start_s[g] = glitch && (acc_n == 5);
      if (stall && !win_ready_s[g] && win_valid_s[g]) begin
        sc++;
        if (sc == 6) win_ready_s[g] = 1'b1;
      end
      if (rst_after >= 0 && acc_n == rst_after + 1) begin
        reset = 1'b0;
        #1;
        check(g, "imm_rst_in_ready", in_ready_s[g], 0);
        check(g, "imm_rst_lb_shift", lb_shift_en_s[g], 0);
        check(g, "imm_rst_busy", busy_s[g], 0);
        check(g, "imm_rst_win_valid", win_valid_s[g], 0);
        in_valid_s[g] = 1'b0; start_s[g] = 1'b0; win_ready_s[g] = 1'b1;
        return;
      end
    end
    in_valid_s[g] = 1'b0; start_s[g] = 1'b0; win_ready_s[g] = 1'b1;
    if (!done) check(g, "frame_timeout", 0, 1);
  endtask

  task automatic check_frame(input int g, input int npix, input int et[4], input int ew[4], input int est);
    check(g, "n_trig", trig_log[g].size(), 4);
    check(g, "n_win", win_log[g].size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < trig_log[g].size()) check(g, "trig_pixel", trig_log[g][i], et[i]);
      if (i < win_log[g].size())  check(g, "win_coord", win_log[g][i], ew[i]);
    end
    check(g, "n_pixels", din_log[g].size(), npix);
    for (int i = 0; i < din_log[g].size(); i++) check(g, "pixel_order", din_log[g][i], i);
    check(g, "model_stall", mstall[g], est);
  endtask

  initial begin
    bit d;
    int t1[4], t2[4], wc[4];
    t1 = '{10, 11, 14, 15};
    t2 = '{12, 14, 22, 24};
    wc = '{0, 1, 16, 17};
    reset = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; in_valid_s[g] = 1'b0; in_data_s[g] = 16'd0; win_ready_s[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Plain 4x4 frame
    run_frame(0, 16, 1'b0, -1, 1'b0, d);
    check(0, "t1_done", d, 1);
    check_frame(0, 16, t1, wc, 0);

    // First window stalled for five cycles
    run_frame(0, 16, 1'b1, -1, 1'b0, d);
    check(0, "t3_done", d, 1);
    check_frame(0, 16, t1, wc, 5);

    // Reset mid-frame after pixel 7, then a clean frame
    run_frame(0, 16, 1'b0, 7, 1'b0, d);
    check(0, "t4_no_done", d, 0);
    check(0, "t4_no_windows", trig_log[0].size(), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_frame(0, 16, 1'b0, -1, 1'b0, d);
    check(0, "t4b_done", d, 1);
    check_frame(0, 16, t1, wc, 0);

    // Stray start during RUN
    run_frame(0, 16, 1'b0, -1, 1'b1, d);
    check(0, "t5_done", d, 1);
    check_frame(0, 16, t1, wc, 0);

    // 5x5 stride 2
    run_frame(1, 25, 1'b0, -1, 1'b0, d);
    check(1, "t2_done", d, 1);
    check_frame(1, 25, t2, wc, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
